// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   localparam int unsigned WORD_BYTES = 4;

   // Word aligned and strictly below the byte limit (unsigned compare).
   function automatic logic addr_legal(input logic [31:0] add, input logic [31:0] byte_limit);
      return (add[1:0] == 2'b00) && (add < byte_limit);
   endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: bit 0 = fetch, bit 1 = data; a tie goes to the port that did not win last.
module mem_arb_rr2 (
   input  logic [1:0] req,
   input  logic       last_data,
   output logic [1:0] gnt
);

   assign gnt[0] = req[0] & (~req[1] | last_data);
   assign gnt[1] = req[1] & (~req[0] | ~last_data);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch (read-only) and load/store,
// granting one access per cycle with the response exactly one cycle later.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_i_req_i,
   input  logic [31:0] s_i_add_i,
   output logic        s_i_gnt_o,
   output logic        s_i_rvalid_o,
   output logic [31:0] s_i_rdata_o,
   output logic        s_i_err_o,
   input  logic        s_d_req_i,
   input  logic        s_d_we_i,
   input  logic [31:0] s_d_add_i,
   input  logic [31:0] s_d_wdata_i,
   output logic        s_d_gnt_o,
   output logic        s_d_rvalid_o,
   output logic [31:0] s_d_rdata_o,
   output logic        s_d_err_o,
   output logic [31:0] s_mem_add_o,
   output logic [31:0] s_mem_val_o,
   output logic        s_mem_write_o,
   input  logic [31:0] s_mem_val_i
);

   localparam logic [31:0] BYTE_LIMIT = 32'(WORD_BYTES * MEM_SIZE);

   logic [1:0]  req;
   logic [1:0]  gnt_rr;
   logic [1:0]  gnt;
   logic [31:0] port_add [2];
   logic [1:0]  port_legal;
   logic [1:0]  resp_valid;

   owner_e      owner_reg;
   owner_e      owner_next;
   logic        last_data_reg;
   logic        we_reg;
   logic        err_reg;
   logic [31:0] wdata_reg;

   assign req         = {s_d_req_i, s_i_req_i};
   assign port_add[0] = s_i_add_i;
   assign port_add[1] = s_d_add_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         assign port_legal[gi] = addr_legal(port_add[gi], BYTE_LIMIT);
      end
   endgenerate

   mem_arb_rr2 u_rr2 (
      .req       (req),
      .last_data (last_data_reg),
      .gnt       (gnt_rr)
   );

   // No grant may be issued while reset is asserted.
   assign gnt       = s_reset_i ? 2'b00 : gnt_rr;
   assign s_i_gnt_o = gnt[0];
   assign s_d_gnt_o = gnt[1];

   always_comb begin
      owner_next    = OWN_NONE;
      s_mem_add_o   = 32'd0;
      s_mem_write_o = 1'b0;
      if (gnt[0]) begin
         owner_next = OWN_FETCH;
         if (port_legal[0]) begin
            s_mem_add_o = s_i_add_i;
         end
      end else if (gnt[1]) begin
         owner_next = OWN_DATA;
         if (port_legal[1]) begin
            s_mem_add_o   = s_d_add_i;
            s_mem_write_o = s_d_we_i;
         end
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         owner_reg     <= OWN_NONE;
         last_data_reg <= 1'b1;
         we_reg        <= 1'b0;
         err_reg       <= 1'b0;
         wdata_reg     <= 32'd0;
      end else begin
         owner_reg <= owner_next;
         if (gnt != 2'b00) begin
            last_data_reg <= gnt[1];
         end
         we_reg    <= gnt[1] & s_d_we_i;
         err_reg   <= (gnt[0] & ~port_legal[0]) | (gnt[1] & ~port_legal[1]);
         wdata_reg <= gnt[1] ? s_d_wdata_i : 32'd0;
      end
   end

   // Write data lags the address by a cycle to line up with the memory's registered address.
   assign s_mem_val_o = wdata_reg;

   assign resp_valid[0] = ~s_reset_i & (owner_reg == OWN_FETCH);
   assign resp_valid[1] = ~s_reset_i & (owner_reg == OWN_DATA);

   assign s_i_rvalid_o = resp_valid[0];
   assign s_i_err_o    = resp_valid[0] & err_reg;
   assign s_i_rdata_o  = (resp_valid[0] & ~err_reg) ? s_mem_val_i : 32'd0;

   assign s_d_rvalid_o = resp_valid[1];
   assign s_d_err_o    = resp_valid[1] & err_reg;
   assign s_d_rdata_o  = (resp_valid[1] & ~err_reg & ~we_reg) ? s_mem_val_i : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-address word memory.
module tb_mem_arbiter;

   logic        s_clk_i = 1'b0;
   logic        s_reset_i = 1'b1;
   logic        s_i_req_i = 1'b0;
   logic [31:0] s_i_add_i = 32'd0;
   logic        s_i_gnt_o;
   logic        s_i_rvalid_o;
   logic [31:0] s_i_rdata_o;
   logic        s_i_err_o;
   logic        s_d_req_i = 1'b0;
   logic        s_d_we_i = 1'b0;
   logic [31:0] s_d_add_i = 32'd0;
   logic [31:0] s_d_wdata_i = 32'd0;
   logic        s_d_gnt_o;
   logic        s_d_rvalid_o;
   logic [31:0] s_d_rdata_o;
   logic        s_d_err_o;
   logic [31:0] s_mem_add_o;
   logic [31:0] s_mem_val_o;
   logic        s_mem_write_o;
   logic [31:0] s_mem_val_i;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 s_clk_i = ~s_clk_i;

   mem_arbiter #(.MEM_SIZE(1024)) dut (
      .s_clk_i       (s_clk_i),
      .s_reset_i     (s_reset_i),
      .s_i_req_i     (s_i_req_i),
      .s_i_add_i     (s_i_add_i),
      .s_i_gnt_o     (s_i_gnt_o),
      .s_i_rvalid_o  (s_i_rvalid_o),
      .s_i_rdata_o   (s_i_rdata_o),
      .s_i_err_o     (s_i_err_o),
      .s_d_req_i     (s_d_req_i),
      .s_d_we_i      (s_d_we_i),
      .s_d_add_i     (s_d_add_i),
      .s_d_wdata_i   (s_d_wdata_i),
      .s_d_gnt_o     (s_d_gnt_o),
      .s_d_rvalid_o  (s_d_rvalid_o),
      .s_d_rdata_o   (s_d_rdata_o),
      .s_d_err_o     (s_d_err_o),
      .s_mem_add_o   (s_mem_add_o),
      .s_mem_val_o   (s_mem_val_o),
      .s_mem_write_o (s_mem_write_o),
      .s_mem_val_i   (s_mem_val_i)
   );

   // Memory model: address/write registered, write data taken in the following cycle.
   logic [31:0] mem [1024];
   logic [31:0] mem_add_q = 32'd0;
   logic        mem_we_q = 1'b0;
   logic        mem_loaded = 1'b0;

   always @(posedge s_clk_i) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 | 32'(i);
         mem[4]     <= 32'hDEAD_BEEF;
         mem_loaded <= 1'b1;
      end else if (mem_we_q) begin
         mem[mem_add_q[11:2]] <= s_mem_val_o;
      end
      mem_add_q <= s_mem_add_o;
      mem_we_q  <= s_mem_write_o;
   end

   assign s_mem_val_i = mem[mem_add_q[11:2]];

   task automatic tick();
      @(posedge s_clk_i);
      #1;
   endtask

   task automatic test_reset();
      tick();
      s_i_req_i = 1'b1;
      s_d_req_i = 1'b1;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o, s_mem_write_o} !== 5'b0) begin
         $display("FAIL reset_ctl: got gnt=%b%b rvalid=%b%b wr=%b want all 0",
                  s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o, s_mem_write_o);
      end else n_pass++;
      n_checks++;
      if ({s_mem_add_o, s_i_rdata_o, s_d_rdata_o, s_i_err_o, s_d_err_o} !== 98'd0) begin
         $display("FAIL reset_data: got add=%h irdata=%h drdata=%h err=%b%b want 0",
                  s_mem_add_o, s_i_rdata_o, s_d_rdata_o, s_i_err_o, s_d_err_o);
      end else n_pass++;
      tick();
      s_reset_i = 1'b0;
      s_i_req_i = 1'b0;
      s_d_req_i = 1'b0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o, s_mem_write_o, s_mem_add_o} !== 37'd0) begin
         $display("FAIL idle: got gnt=%b%b rvalid=%b%b wr=%b add=%h want all 0",
                  s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o, s_mem_write_o, s_mem_add_o);
      end else n_pass++;
   endtask

   task automatic test_fetch();
      tick();
      s_i_req_i = 1'b1;
      s_i_add_i = 32'h10;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_gnt_o, s_d_gnt_o, s_mem_write_o, s_mem_add_o} !== {3'b100, 32'h10}) begin
         $display("FAIL fetch_req: got gnt=%b%b wr=%b add=%h want gnt=10 wr=0 add=00000010",
                  s_i_gnt_o, s_d_gnt_o, s_mem_write_o, s_mem_add_o);
      end else n_pass++;
      tick();
      s_i_req_i = 1'b0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_rvalid_o, s_i_err_o, s_i_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
         $display("FAIL fetch_resp: got rvalid=%b err=%b rdata=%h want 1 0 deadbeef",
                  s_i_rvalid_o, s_i_err_o, s_i_rdata_o);
      end else n_pass++;
      n_checks++;
      if ({s_d_rvalid_o, s_d_err_o, s_d_rdata_o, s_d_gnt_o} !== 35'd0) begin
         $display("FAIL fetch_dport_quiet: got rvalid=%b err=%b rdata=%h gnt=%b want 0",
                  s_d_rvalid_o, s_d_err_o, s_d_rdata_o, s_d_gnt_o);
      end else n_pass++;
   endtask

   task automatic test_write_read();
      tick();
      s_d_req_i   = 1'b1;
      s_d_we_i    = 1'b1;
      s_d_add_i   = 32'h20;
      s_d_wdata_i = 32'h1234_5678;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_d_gnt_o, s_mem_write_o, s_mem_add_o} !== {2'b11, 32'h20}) begin
         $display("FAIL wr_req: got gnt=%b wr=%b add=%h want 1 1 00000020",
                  s_d_gnt_o, s_mem_write_o, s_mem_add_o);
      end else n_pass++;
      tick();
      s_d_we_i    = 1'b0;
      s_d_wdata_i = 32'h0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_d_rvalid_o, s_d_err_o, s_d_rdata_o, s_mem_val_o} !== {2'b10, 32'h0, 32'h1234_5678}) begin
         $display("FAIL wr_ack: got rvalid=%b err=%b rdata=%h memval=%h want 1 0 00000000 12345678",
                  s_d_rvalid_o, s_d_err_o, s_d_rdata_o, s_mem_val_o);
      end else n_pass++;
      n_checks++;
      if ({s_d_gnt_o, s_mem_write_o, s_mem_add_o} !== {2'b10, 32'h20}) begin
         $display("FAIL rd_req: got gnt=%b wr=%b add=%h want 1 0 00000020",
                  s_d_gnt_o, s_mem_write_o, s_mem_add_o);
      end else n_pass++;
      tick();
      s_d_req_i = 1'b0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_d_rvalid_o, s_d_err_o, s_d_rdata_o} !== {2'b10, 32'h1234_5678}) begin
         $display("FAIL rd_resp: got rvalid=%b err=%b rdata=%h want 1 0 12345678",
                  s_d_rvalid_o, s_d_err_o, s_d_rdata_o);
      end else n_pass++;
   endtask

   task automatic test_arbitration();
      logic [1:0]  exp_gnt;
      logic [1:0]  exp_rv;
      logic [63:0] exp_rdata;
      // Make fetch the last winner so the reset value of last-winner matters.
      tick();
      s_i_req_i = 1'b1;
      s_i_add_i = 32'h0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_gnt_o, s_d_gnt_o} !== 2'b10) begin
         $display("FAIL arb_pre: got gnt=%b%b want 10", s_i_gnt_o, s_d_gnt_o);
      end else n_pass++;
      tick();
      s_i_req_i = 1'b0;
      s_reset_i = 1'b1;
      tick();
      s_reset_i = 1'b0;
      s_i_req_i = 1'b1;
      s_i_add_i = 32'h0;
      s_d_req_i = 1'b1;
      s_d_we_i  = 1'b0;
      s_d_add_i = 32'h4;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) tick();
         if (k == 6) begin
            s_i_req_i = 1'b0;
            s_d_req_i = 1'b0;
         end
         exp_gnt = (k == 6) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
         exp_rv  = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
         exp_rdata = {exp_rv[1] ? 32'h1000_0000 : 32'h0, exp_rv[0] ? 32'h1000_0001 : 32'h0};
         @(negedge s_clk_i);
         n_checks++;
         if ({s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o} !== {exp_gnt, exp_rv}) begin
            $display("FAIL arb_cycle%0d: got gnt=%b%b rvalid=%b%b want gnt=%b rvalid=%b",
                     k, s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o, exp_gnt, exp_rv);
         end else n_pass++;
         n_checks++;
         if ({s_i_rdata_o, s_d_rdata_o} !== exp_rdata) begin
            $display("FAIL arb_rdata%0d: got %h %h want %h", k, s_i_rdata_o, s_d_rdata_o, exp_rdata);
         end else n_pass++;
      end
   endtask

   task automatic test_illegal();
      tick();
      s_d_req_i   = 1'b1;
      s_d_we_i    = 1'b1;
      s_d_add_i   = 32'h1002;
      s_d_wdata_i = 32'hBAD0_BAD0;
      s_i_req_i   = 1'b1;
      s_i_add_i   = 32'h1000;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_gnt_o, s_d_gnt_o, s_mem_write_o, s_mem_add_o} !== {3'b100, 32'h0}) begin
         $display("FAIL ill_fetch_req: got gnt=%b%b wr=%b add=%h want 10 0 00000000",
                  s_i_gnt_o, s_d_gnt_o, s_mem_write_o, s_mem_add_o);
      end else n_pass++;
      tick();
      s_i_req_i = 1'b0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_gnt_o, s_d_gnt_o, s_mem_write_o, s_mem_add_o} !== {3'b010, 32'h0}) begin
         $display("FAIL ill_data_req: got gnt=%b%b wr=%b add=%h want 01 0 00000000",
                  s_i_gnt_o, s_d_gnt_o, s_mem_write_o, s_mem_add_o);
      end else n_pass++;
      n_checks++;
      if ({s_i_rvalid_o, s_i_err_o, s_i_rdata_o} !== {2'b11, 32'h0}) begin
         $display("FAIL ill_fetch_resp: got rvalid=%b err=%b rdata=%h want 1 1 00000000",
                  s_i_rvalid_o, s_i_err_o, s_i_rdata_o);
      end else n_pass++;
      tick();
      s_d_req_i = 1'b0;
      s_d_we_i  = 1'b0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_d_rvalid_o, s_d_err_o, s_d_rdata_o, s_i_rvalid_o} !== {2'b11, 32'h0, 1'b0}) begin
         $display("FAIL ill_data_resp: got rvalid=%b err=%b rdata=%h irvalid=%b want 1 1 00000000 0",
                  s_d_rvalid_o, s_d_err_o, s_d_rdata_o, s_i_rvalid_o);
      end else n_pass++;
      tick();
      @(negedge s_clk_i);
      n_checks++;
      if ({mem[0], mem[1023]} !== {32'h1000_0000, 32'h1000_03FF}) begin
         $display("FAIL ill_mem_intact: got %h %h want 10000000 100003ff", mem[0], mem[1023]);
      end else n_pass++;
   endtask

   task automatic test_reset_mid();
      tick();
      s_d_req_i = 1'b1;
      s_d_we_i  = 1'b0;
      s_d_add_i = 32'h8;
      @(negedge s_clk_i);
      n_checks++;
      if (s_d_gnt_o !== 1'b1) begin
         $display("FAIL rst_mid_gnt: got %b want 1", s_d_gnt_o);
      end else n_pass++;
      tick();
      s_reset_i = 1'b1;
      s_i_req_i = 1'b1;
      s_i_add_i = 32'h0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_d_rvalid_o, s_i_gnt_o, s_d_gnt_o} !== 3'b000) begin
         $display("FAIL rst_mid_hold: got drvalid=%b gnt=%b%b want 0 00",
                  s_d_rvalid_o, s_i_gnt_o, s_d_gnt_o);
      end else n_pass++;
      tick();
      s_reset_i = 1'b0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o} !== 4'b1000) begin
         $display("FAIL rst_mid_tie: got gnt=%b%b rvalid=%b%b want gnt=10 rvalid=00",
                  s_i_gnt_o, s_d_gnt_o, s_i_rvalid_o, s_d_rvalid_o);
      end else n_pass++;
      tick();
      s_i_req_i = 1'b0;
      s_d_req_i = 1'b0;
      @(negedge s_clk_i);
      n_checks++;
      if ({s_i_rvalid_o, s_d_rvalid_o, s_i_rdata_o} !== {2'b10, 32'h1000_0000}) begin
         $display("FAIL rst_mid_after: got rvalid=%b%b rdata=%h want 10 10000000",
                  s_i_rvalid_o, s_d_rvalid_o, s_i_rdata_o);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_add;
      logic [31:0] exp_rdata;
      for (int k = 0; k < 4; k++) begin
         tick();
         s_i_req_i = (k < 3);
         s_i_add_i = 32'(4 * k);
         exp_add   = (k < 3) ? 32'(4 * k) : 32'h0;
         exp_rdata = (k > 0) ? (32'h1000_0000 | 32'(k - 1)) : 32'h0;
         @(negedge s_clk_i);
         n_checks++;
         if ({s_i_gnt_o, s_mem_add_o} !== {(k < 3), exp_add}) begin
            $display("FAIL b2b_req%0d: got gnt=%b add=%h want gnt=%b add=%h",
                     k, s_i_gnt_o, s_mem_add_o, (k < 3), exp_add);
         end else n_pass++;
         n_checks++;
         if ({s_i_rvalid_o, s_i_rdata_o} !== {(k > 0), exp_rdata}) begin
            $display("FAIL b2b_resp%0d: got rvalid=%b rdata=%h want %b %h",
                     k, s_i_rvalid_o, s_i_rdata_o, (k > 0), exp_rdata);
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_write_read();
      test_arbitration();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
